// File: rtl/sb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sb_bus_arbiter
//
// Round-robin arbiter for the shared SB bus. It collects bus requests and lock
// requests from up to NUM_MASTERS masters. It drives a registered one-hot grant
// and the matching master index, which selects the SB address/control/data mux.
// A master that received a SPLIT response is masked out until its slave
// releases it. A locked sequence keeps the bus with its owner.
//
// Parameters
//   NUM_MASTERS     number of requesting masters (2..8)
//   ID_WIDTH        width of sb_master_id, at least clog2(NUM_MASTERS)
//   DEFAULT_MASTER  master that is parked on the bus when nobody requests
//
// Ports
//   sb_clk            in   bus clock, all state changes on the rising edge
//   sb_reset          in   synchronous active-high reset
//   sb_busreq         in   bit i: master i requests the bus
//   sb_lock           in   bit i: master i requests a locked access
//   sb_trans          in   trans of the current owner (IDLE0 BUSY1 NONSEQ2 SEQ3)
//   sb_ready          in   muxed slave ready
//   sb_resp           in   muxed slave response (OKAY1 ERROR2 SPLIT3)
//   sb_split_release  in   bit i: the slave re-enables split master i
//   sb_grant          out  one-hot grant; all zero only when parked on nobody
//   sb_master_id      out  index of the current owner (SB mux select)
//   sb_mastlock       out  current transfer belongs to a locked sequence
//   sb_parked         out  no unmasked requester, bus parked
// -----------------------------------------------------------------------------
module sb_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   sb_clk,
  input  logic                   sb_reset,
  input  logic [NUM_MASTERS-1:0] sb_busreq,
  input  logic [NUM_MASTERS-1:0] sb_lock,
  input  logic [1:0]             sb_trans,
  input  logic                   sb_ready,
  input  logic [1:0]             sb_resp,
  input  logic [NUM_MASTERS-1:0] sb_split_release,
  output logic [NUM_MASTERS-1:0] sb_grant,
  output logic [ID_WIDTH-1:0]    sb_master_id,
  output logic                   sb_mastlock,
  output logic                   sb_parked
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] RESP_SPLIT   = 2'd3;

  localparam logic [ID_WIDTH-1:0] DEFAULT_ID = ID_WIDTH'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    ARB_PARK  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_SPLIT = 2'd2
  } arb_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e             state_q, state_d;
  logic [ID_WIDTH-1:0]    owner_q, owner_d;
  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] split_mask_q, split_mask_d;
  logic                   locked_q, locked_d;
  logic                   parked_q, parked_d;

  // ---------------------------------------------------------------------------
  // Qualifiers for the current cycle
  // ---------------------------------------------------------------------------
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] scan_req;
  logic [NUM_MASTERS-1:0] split_set;
  logic                   pick_valid;
  logic [ID_WIDTH-1:0]    pick_idx;
  logic                   owner_req;
  logic                   split_rsp;
  logic                   lock_now;
  logic                   unlock_now;
  logic                   locked_eff;
  logic                   rearb_point;

  assign eligible  = sb_busreq & ~split_mask_q;
  assign owner_req = sb_busreq[owner_q];

  // A SPLIT is recognised on its first response cycle (ready still low).
  assign split_rsp = (state_q == ARB_OWN) && !sb_ready && (sb_resp == RESP_SPLIT);

  // The lock takes effect in the NONSEQ cycle itself, so that cycle can
  // never become a rearbitration point.
  assign lock_now   = sb_lock[owner_q] && (sb_trans == TRANS_NONSEQ);
  // Unlocking happens in an otherwise qualifying cycle. That cycle is then
  // also a rearbitration point, so the bus is handed on without a gap.
  assign unlock_now = locked_q && sb_ready && (sb_trans == TRANS_IDLE) &&
                      !sb_lock[owner_q];
  assign locked_eff = (locked_q && !unlock_now) || lock_now;

  // A burst in flight (SEQ/BUSY with the request still held) never yields.
  assign rearb_point = sb_ready && !locked_eff &&
                       ((sb_trans == TRANS_IDLE) || !owner_req);

  // While leaving a split, the split owner is excluded explicitly. This
  // matters even if its release arrives in the same cycle.
  always_comb begin
    scan_req = eligible;
    if (state_q == ARB_SPLIT) begin
      scan_req[owner_q] = 1'b0;
    end
  end

  // Round-robin pick. The scan starts at rr_ptr+1 and wraps, so the previous
  // owner is considered last. The loop runs from the far end down, which
  // leaves the nearest eligible index as the final assignment.
  // NOTE: every variable written in an always_comb receives a default before
  // any conditional assignment, so no path can hold a stale value (no latch).
  always_comb begin : rr_pick
    logic [ID_WIDTH-1:0] scan_idx;
    pick_valid = 1'b0;
    pick_idx   = DEFAULT_ID;
    scan_idx   = DEFAULT_ID;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      scan_idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_MASTERS);
      if (scan_req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    logic go_own;
    logic go_park;

    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    locked_d  = locked_q;
    split_set = '0;
    go_own    = 1'b0;
    go_park   = 1'b0;

    unique case (state_q)
      ARB_PARK: begin
        // An idle bus has no transfer to protect, so any eligible requester
        // is granted immediately.
        if (pick_valid) begin
          go_own = 1'b1;
        end
      end

      ARB_OWN: begin
        if (split_rsp) begin
          // Lock does not protect the owner against a SPLIT.
          state_d            = ARB_SPLIT;
          split_set[owner_q] = 1'b1;
          locked_d           = 1'b0;
        end else if (rearb_point && !pick_valid) begin
          go_park = 1'b1;
        end else if (rearb_point && (pick_idx != owner_q)) begin
          go_own = 1'b1;
        end else begin
          locked_d = locked_eff;
        end
      end

      ARB_SPLIT: begin
        // Second response cycle: the bus is free for someone else.
        if (sb_ready) begin
          if (pick_valid) begin
            go_own = 1'b1;
          end else begin
            go_park = 1'b1;
          end
        end
      end

      default: begin
        go_park = 1'b1;
      end
    endcase

    // A new owner starts unlocked; its own NONSEQ with lock sets the lock.
    if (go_own) begin
      state_d  = ARB_OWN;
      owner_d  = pick_idx;
      rr_ptr_d = pick_idx;
      locked_d = 1'b0;
    end
    // Parking leaves rr_ptr alone, so fairness continues from the last owner.
    if (go_park) begin
      state_d  = ARB_PARK;
      owner_d  = DEFAULT_ID;
      locked_d = 1'b0;
    end
  end

  // A set and a release on the same master in the same cycle leave the bit
  // set. A release of a clear bit has no effect.
  assign split_mask_d = (split_mask_q & ~sb_split_release) | split_set;

  // The grant is derived from the next owner. Grant and master_id are
  // therefore registered from the same source and always move together.
  // A parked default master that is itself split receives no grant.
  always_comb begin
    grant_d = '0;
    if (state_d == ARB_PARK) begin
      if (!split_mask_d[DEFAULT_ID]) begin
        grant_d[DEFAULT_ID] = 1'b1;
      end
    end else begin
      grant_d[owner_d] = 1'b1;
    end
  end

  assign parked_d = (state_d == ARB_PARK);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge sb_clk) begin
    if (sb_reset) begin
      state_q      <= ARB_PARK;
      owner_q      <= DEFAULT_ID;
      rr_ptr_q     <= DEFAULT_ID;
      grant_q      <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      split_mask_q <= '0;
      locked_q     <= 1'b0;
      parked_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      split_mask_q <= split_mask_d;
      locked_q     <= locked_d;
      parked_q     <= parked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sb_grant     = grant_q;
  assign sb_master_id = owner_q;
  assign sb_mastlock  = locked_q;
  assign sb_parked    = parked_q;

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_bus_arbiter
//
// Directed bench for sb_bus_arbiter (4 masters, default master 0). Each step
// drives one cycle of inputs. It queues the hand-computed outputs expected
// after that edge. A monitor process pops one entry after every edge and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sb_bus_arbiter;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;
  localparam logic [1:0] OKAY   = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;
  localparam logic [1:0] SPLIT  = 2'd3;

  logic       sb_clk;
  logic       sb_reset;
  logic [3:0] sb_busreq;
  logic [3:0] sb_lock;
  logic [1:0] sb_trans;
  logic       sb_ready;
  logic [1:0] sb_resp;
  logic [3:0] sb_split_release;
  logic [3:0] sb_grant;
  logic [1:0] sb_master_id;
  logic       sb_mastlock;
  logic       sb_parked;

  sb_bus_arbiter #(
    .NUM_MASTERS   (4),
    .ID_WIDTH      (2),
    .DEFAULT_MASTER(0)
  ) dut (
    .sb_clk          (sb_clk),
    .sb_reset        (sb_reset),
    .sb_busreq       (sb_busreq),
    .sb_lock         (sb_lock),
    .sb_trans        (sb_trans),
    .sb_ready        (sb_ready),
    .sb_resp         (sb_resp),
    .sb_split_release(sb_split_release),
    .sb_grant        (sb_grant),
    .sb_master_id    (sb_master_id),
    .sb_mastlock     (sb_mastlock),
    .sb_parked       (sb_parked)
  );

  initial sb_clk = 1'b0;
  always #5 sb_clk = ~sb_clk;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] id;
    logic       mastlock;
    logic       parked;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One bus cycle: drive inputs, queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] lck,
                      input logic [1:0] tr, input logic rdy, input logic [1:0] rsp,
                      input logic [3:0] rel, input logic [3:0] eg, input logic [1:0] eid,
                      input logic eml, input logic epk, input string nm);
    exp_t e;
    sb_reset         = rst;
    sb_busreq        = req;
    sb_lock          = lck;
    sb_trans         = tr;
    sb_ready         = rdy;
    sb_resp          = rsp;
    sb_split_release = rel;
    e.name     = nm;
    e.grant    = eg;
    e.id       = eid;
    e.mastlock = eml;
    e.parked   = epk;
    exp_q.push_back(e);
    @(posedge sb_clk);
    #1;
  endtask

  // Monitor: sample 2 time units after each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge sb_clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".grant"},    32'(sb_grant),     32'(e.grant));
        check({e.name, ".id"},       32'(sb_master_id), 32'(e.id));
        check({e.name, ".mastlock"}, 32'(sb_mastlock),  32'(e.mastlock));
        check({e.name, ".parked"},   32'(sb_parked),    32'(e.parked));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    //    rst  busreq   lock     trans   rdy resp  release  grant    id    ml pk
    // Reset and park, then a single requester.
    step(1, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t1_reset");
    step(0, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t1_park");
    step(0, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0100, 2'd2, 0, 0, "t1_req2");
    // M0 takes over, then all four request: strict rotation.
    step(0, 4'b0001, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t2_own0");
    step(0, 4'b1111, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t2_rot1");
    step(0, 4'b1111, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0100, 2'd2, 0, 0, "t2_rot2");
    step(0, 4'b1111, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b1000, 2'd3, 0, 0, "t2_rot3");
    step(0, 4'b1111, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t2_rot0");
    // M1 locked NONSEQ + 3 SEQ, lock held through one IDLE, then released.
    step(0, 4'b1111, 4'b0010, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t3_own1");
    step(0, 4'b1111, 4'b0010, NONSEQ, 1, OKAY,  4'b0000, 4'b0010, 2'd1, 1, 0, "t3_nonseq");
    step(0, 4'b1111, 4'b0010, SEQ,    1, OKAY,  4'b0000, 4'b0010, 2'd1, 1, 0, "t3_seq1");
    step(0, 4'b1111, 4'b0010, SEQ,    1, OKAY,  4'b0000, 4'b0010, 2'd1, 1, 0, "t3_seq2");
    step(0, 4'b1111, 4'b0010, SEQ,    1, OKAY,  4'b0000, 4'b0010, 2'd1, 1, 0, "t3_seq3");
    step(0, 4'b1111, 4'b0010, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 1, 0, "t3_idle_locked");
    step(0, 4'b1111, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0100, 2'd2, 0, 0, "t3_unlock");
    // M2 split, M1 takes over, release re-enables M2.
    step(0, 4'b0110, 4'b0000, NONSEQ, 0, SPLIT, 4'b0000, 4'b0100, 2'd2, 0, 0, "t4_split");
    step(0, 4'b0110, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t4_to1");
    step(0, 4'b0110, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t4_masked");
    step(0, 4'b0110, 4'b0000, IDLE,   1, OKAY,  4'b0100, 4'b0010, 2'd1, 0, 0, "t4_release");
    step(0, 4'b0110, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0100, 2'd2, 0, 0, "t4_regrant2");
    // Split and release together: the split wins.
    step(0, 4'b0110, 4'b0000, NONSEQ, 0, SPLIT, 4'b0100, 4'b0100, 2'd2, 0, 0, "t4_set_rel");
    step(0, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t4_park");
    step(0, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t4_set_won");
    step(0, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0100, 4'b0001, 2'd0, 0, 1, "t4_rel2");
    step(0, 4'b0100, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0100, 2'd2, 0, 0, "t4_back2");
    step(0, 4'b0110, 4'b0000, NONSEQ, 0, ERROR, 4'b0000, 4'b0100, 2'd2, 0, 0, "t4_error");
    // All requesters split: park on nobody, release brings M1 back.
    step(1, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t5_reset");
    step(0, 4'b0011, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t5_own1");
    step(0, 4'b0011, 4'b0000, NONSEQ, 0, SPLIT, 4'b0000, 4'b0010, 2'd1, 0, 0, "t5_split1");
    step(0, 4'b0011, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t5_own0");
    step(0, 4'b0011, 4'b0000, NONSEQ, 0, SPLIT, 4'b0000, 4'b0001, 2'd0, 0, 0, "t5_split0");
    step(0, 4'b0011, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0000, 2'd0, 0, 1, "t5_nobody");
    step(0, 4'b0011, 4'b0000, IDLE,   1, OKAY,  4'b0010, 4'b0000, 2'd0, 0, 1, "t5_rel1");
    step(0, 4'b0011, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t5_grant1");
    // M3 locked burst interrupted by reset.
    step(0, 4'b1000, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b1000, 2'd3, 0, 0, "t6_own3");
    step(0, 4'b1000, 4'b1000, NONSEQ, 1, OKAY,  4'b0000, 4'b1000, 2'd3, 1, 0, "t6_nonseq");
    step(0, 4'b1000, 4'b1000, SEQ,    1, OKAY,  4'b0000, 4'b1000, 2'd3, 1, 0, "t6_seq");
    step(1, 4'b1000, 4'b1000, SEQ,    1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t6_reset");
    step(0, 4'b0001, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t6_mask_clear");
    // A burst holds the bus; a master that dropped busreq is not re-picked.
    step(0, 4'b0011, 4'b0000, SEQ,    1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t7_burst_hold");
    step(0, 4'b0010, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0010, 2'd1, 0, 0, "t7_drop0");
    step(0, 4'b0001, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 0, "t7_drop1");
    step(0, 4'b0000, 4'b0000, IDLE,   1, OKAY,  4'b0000, 4'b0001, 2'd0, 0, 1, "t7_park");

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      @(posedge sb_clk);
      #3;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
